count_modn: RTL and testbench

COUNT_MODN -- requirements
Module: count_modn

---
 rtl/count_modn.sv | 74 +++++++
 tb/tb_count_modn.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/count_modn.sv
// Modulo-N up/down counter with clear, parallel load, zero flag and a
// combinational terminal-count strobe intended for ripple-enable cascading.
module count_modn #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             zero
);

  // Highest legal count, and the modulus widened by one bit so that
  // MODULUS == 2**WIDTH is representable in the load range compare.
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             at_max;
  logic             at_min;

  // Increment with wrap MODULUS-1 -> 0.
  function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] c);
    return (c == MAX_CNT) ? '0 : c + 1'b1;
  endfunction

  // Decrement with wrap 0 -> MODULUS-1.
  function automatic logic [WIDTH-1:0] step_dn(input logic [WIDTH-1:0] c);
    return (c == '0) ? MAX_CNT : c - 1'b1;
  endfunction

  // Out-of-range load values collapse to 0 so the count never leaves 0..MODULUS-1.
  function automatic logic [WIDTH-1:0] load_fix(input logic [WIDTH-1:0] v);
    return ({1'b0, v} < MOD_EXT) ? v : '0;
  endfunction

  assign at_max = (cnt_q == MAX_CNT);
  assign at_min = (cnt_q == '0);

  // Next-count selection: clear, then load, then count step, else hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_fix(load_val);
    end else if (en) begin
      cnt_d = up_dn ? step_up(cnt_q) : step_dn(cnt_q);
    end
  end

  // Count register; active-low reset overrides every other request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // tc is high only when the coming edge will wrap, so it can feed the
  // next stage's en directly without adding a cycle of latency.
  assign tc   = en & ~clr & ~load & (up_dn ? at_max : at_min);
  assign out  = cnt_q;
  assign zero = at_min;

endmodule

// File: tb/tb_count_modn.sv
// Scoreboard bench for count_modn: stimulus pushes expected out/tc/zero per
// cycle into a queue, a negedge monitor pops and compares against the DUTs.
module tb_count_modn;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Per-DUT stimulus: 0 = (3,8), 1 = (4,10), 2 = (3,6), 3 = cascade units (4,10)
  logic       i_rst [4];
  logic       i_en  [4];
  logic       i_up  [4];
  logic       i_clr [4];
  logic       i_ld  [4];
  logic [3:0] i_lv  [4];

  logic [2:0] out8, out6, outt;
  logic [3:0] out10, outu;
  logic       tc8, tc10, tc6, tcu, tct;
  logic       z8, z10, z6, zu, zt;

  // Observation index 4 = cascade tens (3,6)
  logic [3:0] o_out  [5];
  logic       o_tc   [5];
  logic       o_zero [5];

  assign o_out[0] = {1'b0, out8};  assign o_tc[0] = tc8;  assign o_zero[0] = z8;
  assign o_out[1] = out10;         assign o_tc[1] = tc10; assign o_zero[1] = z10;
  assign o_out[2] = {1'b0, out6};  assign o_tc[2] = tc6;  assign o_zero[2] = z6;
  assign o_out[3] = outu;          assign o_tc[3] = tcu;  assign o_zero[3] = zu;
  assign o_out[4] = {1'b0, outt};  assign o_tc[4] = tct;  assign o_zero[4] = zt;

  count_modn #(.WIDTH(3), .MODULUS(8)) u_d8 (
    .clk(clk), .rst(i_rst[0]), .en(i_en[0]), .up_dn(i_up[0]), .clr(i_clr[0]),
    .load(i_ld[0]), .load_val(i_lv[0][2:0]), .out(out8), .tc(tc8), .zero(z8));

  count_modn #(.WIDTH(4), .MODULUS(10)) u_d10 (
    .clk(clk), .rst(i_rst[1]), .en(i_en[1]), .up_dn(i_up[1]), .clr(i_clr[1]),
    .load(i_ld[1]), .load_val(i_lv[1]), .out(out10), .tc(tc10), .zero(z10));

  count_modn #(.WIDTH(3), .MODULUS(6)) u_d6 (
    .clk(clk), .rst(i_rst[2]), .en(i_en[2]), .up_dn(i_up[2]), .clr(i_clr[2]),
    .load(i_ld[2]), .load_val(i_lv[2][2:0]), .out(out6), .tc(tc6), .zero(z6));

  count_modn #(.WIDTH(4), .MODULUS(10)) u_units (
    .clk(clk), .rst(i_rst[3]), .en(i_en[3]), .up_dn(i_up[3]), .clr(i_clr[3]),
    .load(i_ld[3]), .load_val(i_lv[3]), .out(outu), .tc(tcu), .zero(zu));

  count_modn #(.WIDTH(3), .MODULUS(6)) u_tens (
    .clk(clk), .rst(i_rst[3]), .en(tcu), .up_dn(1'b1), .clr(1'b0),
    .load(1'b0), .load_val(3'd0), .out(outt), .tc(tct), .zero(zt));

  typedef struct {
    int k;
    int cyc;
    int eo;
    bit etc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int mod_of(input int k);
    case (k)
      0: return 8;
      1, 3: return 10;
      default: return 6;
    endcase
  endfunction

  function automatic void push(input int k, input int eo, input bit etc);
    exp_t e;
    e.k = k; e.cyc = cyc; e.eo = eo; e.etc = etc;
    q.push_back(e);
  endfunction

  // Monitor: compare every expectation stamped for the current cycle.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_checks++;
      if (o_out[e.k] !== 4'(e.eo)) begin
        n_err++;
        $display("FAIL out dut=%0d cyc=%0d got=%0d exp=%0d", e.k, e.cyc, o_out[e.k], e.eo);
      end
      n_checks++;
      if (o_tc[e.k] !== e.etc) begin
        n_err++;
        $display("FAIL tc dut=%0d cyc=%0d got=%b exp=%b", e.k, e.cyc, o_tc[e.k], e.etc);
      end
      n_checks++;
      if (o_zero[e.k] !== (e.eo == 0)) begin
        n_err++;
        $display("FAIL zero dut=%0d cyc=%0d got=%b exp=%b", e.k, e.cyc, o_zero[e.k], (e.eo == 0));
      end
      n_checks++;
      if (!(int'(o_out[e.k]) < mod_of(e.k))) begin
        n_err++;
        $display("FAIL range dut=%0d cyc=%0d got=%0d limit=%0d", e.k, e.cyc, o_out[e.k], mod_of(e.k));
      end
    end
  end

  // Apply one cycle of inputs to DUT k; when chk is set, queue the values
  // expected to be visible during this cycle (before the coming edge).
  task automatic vec(input int k, input bit r, input bit e, input bit u, input bit c,
                     input bit l, input logic [3:0] lv, input int eo, input bit etc,
                     input bit chk);
    i_rst[k] = r; i_en[k] = e; i_up[k] = u; i_clr[k] = c; i_ld[k] = l; i_lv[k] = lv;
    if (chk) push(k, eo, etc);
    @(posedge clk);
    #1;
  endtask

  // Random traffic against an arithmetic reference model.
  task automatic rand_run(input int k, input int m, input int lv_max, input int n);
    int st;
    bit r, e, u, c, l, etc;
    logic [3:0] lv;
    vec(k, 0, 0, 1, 0, 0, 4'd0, 0, 0, 0);
    st = 0;
    for (int i = 0; i < n; i++) begin
      r  = ($urandom_range(0, 63) != 0);
      c  = ($urandom_range(0, 15) == 0);
      l  = ($urandom_range(0, 7) == 0);
      e  = ($urandom_range(0, 3) != 0);
      u  = 1'($urandom_range(0, 1));
      lv = 4'($urandom_range(0, lv_max));
      etc = e && !c && !l && ((u && st == m - 1) || (!u && st == 0));
      vec(k, r, e, u, c, l, lv, st, etc, 1);
      if (!r)      st = 0;
      else if (c)  st = 0;
      else if (l)  st = (int'(lv) < m) ? int'(lv) : 0;
      else if (e)  st = u ? (st + 1) % m : (st + m - 1) % m;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      i_rst[k] = 1'b1; i_en[k] = 1'b0; i_up[k] = 1'b1;
      i_clr[k] = 1'b0; i_ld[k] = 1'b0; i_lv[k] = 4'd0;
    end
    @(posedge clk);
    #1;

    // (3,8): reset, up through wrap, down through wrap, hold, clear at max
    vec(0, 0, 0, 1, 0, 0, 4'd0, 0, 0, 0);
    for (int i = 0; i < 9; i++) vec(0, 1, 1, 1, 0, 0, 4'd0, i % 8, (i == 7), 1);
    vec(0, 1, 1, 0, 0, 0, 4'd0, 1, 0, 1);
    vec(0, 1, 1, 0, 0, 0, 4'd0, 0, 1, 1);
    vec(0, 1, 0, 0, 0, 0, 4'd0, 7, 0, 1);
    vec(0, 1, 0, 1, 0, 0, 4'd0, 7, 0, 1);
    vec(0, 1, 1, 1, 1, 0, 4'd0, 7, 0, 1);
    vec(0, 1, 0, 0, 0, 0, 4'd0, 0, 0, 1);

    // (4,10): up to 9 and wrap, then down-wrap from 0
    vec(1, 0, 0, 1, 0, 0, 4'd0, 0, 0, 0);
    for (int i = 0; i < 10; i++) vec(1, 1, 1, 1, 0, 0, 4'd0, i, (i == 9), 1);
    vec(1, 1, 1, 0, 0, 0, 4'd0, 0, 1, 1);
    // (4,10): load rules and priorities
    vec(1, 1, 0, 1, 0, 1, 4'd7,  9, 0, 1);
    vec(1, 1, 0, 1, 0, 1, 4'd12, 7, 0, 1);
    vec(1, 1, 0, 1, 0, 1, 4'd3,  0, 0, 1);
    vec(1, 1, 1, 1, 1, 1, 4'd5,  3, 0, 1);
    vec(1, 1, 1, 1, 0, 1, 4'd4,  0, 0, 1);
    vec(1, 1, 1, 1, 0, 1, 4'd9,  4, 0, 1);
    vec(1, 1, 1, 1, 0, 1, 4'd2,  9, 0, 1);
    vec(1, 1, 0, 1, 0, 1, 4'd9,  2, 0, 1);
    vec(1, 1, 1, 1, 1, 0, 4'd0,  9, 0, 1);
    vec(1, 1, 0, 1, 0, 1, 4'd5,  0, 0, 1);
    vec(1, 1, 0, 1, 0, 1, 4'd10, 5, 0, 1);
    vec(1, 1, 1, 0, 0, 1, 4'd15, 0, 0, 1);
    vec(1, 1, 0, 1, 0, 0, 4'd0,  0, 0, 1);
    // (4,10): reset mid-count overrides load and en
    vec(1, 0, 0, 1, 0, 0, 4'd0, 0, 0, 1);
    for (int i = 0; i < 5; i++) vec(1, 1, 1, 1, 0, 0, 4'd0, i, 0, 1);
    vec(1, 0, 1, 1, 0, 1, 4'd7, 5, 0, 1);
    vec(1, 1, 1, 1, 0, 0, 4'd0, 0, 0, 1);
    vec(1, 1, 1, 1, 0, 0, 4'd0, 1, 0, 1);
    vec(1, 1, 0, 1, 0, 0, 4'd0, 2, 0, 1);

    // Cascade: mod-10 units tc drives mod-6 tens en for 60 edges
    vec(3, 0, 0, 1, 0, 0, 4'd0, 0, 0, 0);
    for (int i = 0; i < 60; i++) begin
      push(4, (i / 10) % 6, (i == 59));
      vec(3, 1, 1, 1, 0, 0, 4'd0, i % 10, ((i % 10) == 9), 1);
    end
    push(4, 0, 0);
    vec(3, 1, 0, 1, 0, 0, 4'd0, 0, 0, 1);

    // (3,6): down-wrap, up-wrap, load at the modulus boundary
    vec(2, 0, 0, 1, 0, 0, 4'd0, 0, 0, 0);
    vec(2, 1, 1, 0, 0, 0, 4'd0, 0, 1, 1);
    vec(2, 1, 1, 1, 0, 0, 4'd0, 5, 1, 1);
    vec(2, 1, 1, 1, 0, 0, 4'd0, 0, 0, 1);
    vec(2, 1, 0, 1, 0, 1, 4'd6, 1, 0, 1);
    vec(2, 1, 0, 1, 0, 1, 4'd5, 0, 0, 1);
    vec(2, 1, 0, 1, 0, 0, 4'd0, 5, 0, 1);

    // Random traffic on all three configurations in parallel
    fork
      rand_run(0, 8, 7, 10000);
      rand_run(1, 10, 15, 10000);
      rand_run(2, 6, 7, 10000);
    join

    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
